// File: rtl/ama_riscv_fe_ctrl.sv
// ama_riscv_fe_ctrl: frontend control, overrides decoder PC requests on boot,
// branch resolution, imem back-pressure and backend stall. Optional perf
// counters are enabled with `define FE_CTRL_PERF_EN.
module ama_riscv_fe_ctrl #(
    parameter int BR_RES_LAT = 1,
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    input  logic [1:0]            dec_pc_sel,
    input  logic                  dec_pc_we,
    input  logic                  dec_branch,
    input  logic                  dec_jump,
    input  logic                  ex_br_taken,
    input  logic                  imem_ready,
    input  logic                  be_stall,
`ifdef FE_CTRL_PERF_EN
    output logic [PERF_CNT_W-1:0] perf_br_stall,
    output logic [PERF_CNT_W-1:0] perf_imem_stall,
    output logic [PERF_CNT_W-1:0] perf_redirects,
`endif
    output logic [1:0]            pc_sel,
    output logic                  pc_we,
    output logic                  dec_kill,
    output logic                  busy
);

    localparam logic [1:0] SEL_START = 2'd0;
    localparam logic [1:0] SEL_INC4  = 2'd1;
    localparam logic [1:0] SEL_ALU   = 2'd2;

    localparam logic [2:0] CNT_INIT = 3'(BR_RES_LAT - 1);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        WAIT_BR = 2'd2,
        REDIR   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [2:0] cnt;
    logic [2:0] cnt_n;
    logic       jmp_q;
    logic       jmp_n;
    logic       tgt_q;
    logic       tgt_n;
    logic       is_cf;
    logic       taken;

    assign is_cf = dec_valid & (dec_branch | dec_jump);
    assign taken = jmp_q | ex_br_taken;

    // State, resolution counter and latched branch outcome
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            cnt   <= 3'd0;
            jmp_q <= 1'b0;
            tgt_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            jmp_q <= jmp_n;
            tgt_q <= tgt_n;
        end
    end

    // Next state and final frontend controls
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        jmp_n    = jmp_q;
        tgt_n    = tgt_q;
        pc_sel   = SEL_INC4;
        pc_we    = 1'b0;
        dec_kill = 1'b1;
        unique case (state)
            BOOT: begin
                pc_sel = SEL_START;
                if (imem_ready) begin
                    pc_we   = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (is_cf) begin
                    // jump target comes from the ALU later; hold fetch
                    pc_sel  = SEL_INC4;
                    cnt_n   = CNT_INIT;
                    jmp_n   = dec_jump;
                    state_n = WAIT_BR;
                end else begin
                    pc_sel   = dec_pc_sel;
                    pc_we    = dec_pc_we & imem_ready;
                    dec_kill = !imem_ready;
                end
            end
            WAIT_BR: begin
                if (cnt != 3'd0) begin
                    cnt_n = cnt - 3'd1;
                end else begin
                    tgt_n  = taken;
                    pc_sel = taken ? SEL_ALU : SEL_INC4;
                    if (imem_ready) begin
                        pc_we   = 1'b1;
                        state_n = RUN;
                    end else begin
                        state_n = REDIR;
                    end
                end
            end
            REDIR: begin
                pc_sel = tgt_q ? SEL_ALU : SEL_INC4;
                pc_we  = imem_ready;
                if (imem_ready) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
        // backend stall freezes everything but keeps the select visible
        if (be_stall) begin
            pc_we    = 1'b0;
            dec_kill = 1'b0;
            state_n  = state;
            cnt_n    = cnt;
            jmp_n    = jmp_q;
            tgt_n    = tgt_q;
        end
        if (rst) begin
            pc_sel   = SEL_START;
            pc_we    = 1'b0;
            dec_kill = 1'b1;
        end
    end

    assign busy = rst | (state != RUN);

`ifdef FE_CTRL_PERF_EN
    logic br_inc;
    logic imem_inc;
    logic redir_inc;

    assign br_inc    = ((state == WAIT_BR) | (state == REDIR)) & !be_stall;
    assign imem_inc  = ((state == RUN) | (state == BOOT)) &
                       !imem_ready & !be_stall;
    assign redir_inc = pc_we & (pc_sel == SEL_ALU);

    // Free-running wrap-around performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_stall   <= '0;
            perf_imem_stall <= '0;
            perf_redirects  <= '0;
        end else begin
            if (br_inc) begin
                perf_br_stall <= perf_br_stall + 1'b1;
            end
            if (imem_inc) begin
                perf_imem_stall <= perf_imem_stall + 1'b1;
            end
            if (redir_inc) begin
                perf_redirects <= perf_redirects + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ama_riscv_fe_ctrl.sv
// Testbench for ama_riscv_fe_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_ama_riscv_fe_ctrl;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dec_valid = 1'b0;
    logic [1:0] dec_pc_sel = 2'd0;
    logic       dec_pc_we = 1'b0;
    logic       dec_branch = 1'b0;
    logic       dec_jump = 1'b0;
    logic       ex_br_taken = 1'b0;
    logic       imem_ready = 1'b0;
    logic       be_stall = 1'b0;
    logic [1:0] pc_sel;
    logic       pc_we;
    logic       dec_kill;
    logic       busy;
`ifdef FE_CTRL_PERF_EN
    logic [31:0] perf_br_stall;
    logic [31:0] perf_imem_stall;
    logic [31:0] perf_redirects;
    int p_br = 0;
    int p_im = 0;
    int p_rd = 0;
`endif

    ama_riscv_fe_ctrl #(.BR_RES_LAT(LAT), .PERF_CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .dec_valid   (dec_valid),
        .dec_pc_sel  (dec_pc_sel),
        .dec_pc_we   (dec_pc_we),
        .dec_branch  (dec_branch),
        .dec_jump    (dec_jump),
        .ex_br_taken (ex_br_taken),
        .imem_ready  (imem_ready),
        .be_stall    (be_stall),
`ifdef FE_CTRL_PERF_EN
        .perf_br_stall   (perf_br_stall),
        .perf_imem_stall (perf_imem_stall),
        .perf_redirects  (perf_redirects),
`endif
        .pc_sel      (pc_sel),
        .pc_we       (pc_we),
        .dec_kill    (dec_kill),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // model: pending-resolution countdown and pending redirect
    bit m_boot  = 1'b1;
    bit m_pend  = 1'b0;
    bit m_redir = 1'b0;
    bit m_jmp   = 1'b0;
    bit m_tgt   = 1'b0;
    int m_rem   = 0;

    int e_sel;
    bit e_we;
    bit e_kill;
    bit e_busy;

    int a_sel;
    int a_we;
    int a_kill;
    int a_busy;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        bit n_boot;
        bit n_pend;
        bit n_redir;
        bit n_jmp;
        bit n_tgt;
        int n_rem;
        bit tk;
        #1;
        n_boot = m_boot; n_pend = m_pend; n_redir = m_redir;
        n_jmp = m_jmp; n_tgt = m_tgt; n_rem = m_rem;
        e_busy = 1'b1;
        if (rst) begin
            e_sel = 0; e_we = 0; e_kill = 1;
            n_boot = 1; n_pend = 0; n_redir = 0;
        end else if (m_boot) begin
            e_sel = 0;
            e_we = !be_stall && imem_ready;
            e_kill = !be_stall;
            if (e_we) n_boot = 0;
        end else if (m_pend) begin
            e_kill = !be_stall;
            if (m_rem > 0) begin
                e_sel = 1; e_we = 0;
                if (!be_stall) n_rem = m_rem - 1;
            end else begin
                tk = m_jmp || ex_br_taken;
                e_sel = tk ? 2 : 1;
                e_we = !be_stall && imem_ready;
                if (!be_stall) begin
                    n_pend = 0;
                    if (!imem_ready) begin
                        n_redir = 1; n_tgt = tk;
                    end
                end
            end
        end else if (m_redir) begin
            e_sel = m_tgt ? 2 : 1;
            e_we = !be_stall && imem_ready;
            e_kill = !be_stall;
            if (e_we) n_redir = 0;
        end else begin
            e_busy = 0;
            if (dec_valid && (dec_branch || dec_jump)) begin
                e_sel = 1; e_we = 0; e_kill = !be_stall;
                if (!be_stall) begin
                    n_pend = 1; n_rem = LAT - 1; n_jmp = dec_jump;
                end
            end else begin
                e_sel = int'(dec_pc_sel);
                e_we = !be_stall && dec_pc_we && imem_ready;
                e_kill = !be_stall && !imem_ready;
            end
        end
        a_sel = int'(pc_sel); a_we = int'(pc_we);
        a_kill = int'(dec_kill); a_busy = int'(busy);
        chk("pc_sel", a_sel, e_sel);
        chk("pc_we", a_we, int'(e_we));
        chk("dec_kill", a_kill, int'(e_kill));
        chk("busy", a_busy, int'(e_busy));
`ifdef FE_CTRL_PERF_EN
        if (rst) begin
            p_br = 0; p_im = 0; p_rd = 0;
        end else begin
            if ((m_pend || m_redir) && !be_stall) p_br++;
            if (!m_pend && !m_redir && !imem_ready && !be_stall) p_im++;
            if (e_we && e_sel == 2) p_rd++;
        end
`endif
        @(posedge clk);
        #1;
        m_boot = n_boot; m_pend = n_pend; m_redir = n_redir;
        m_jmp = n_jmp; m_tgt = n_tgt; m_rem = n_rem;
`ifdef FE_CTRL_PERF_EN
        chk("perf_br_stall", int'(perf_br_stall), p_br);
        chk("perf_imem_stall", int'(perf_imem_stall), p_im);
        chk("perf_redirects", int'(perf_redirects), p_rd);
`endif
    endtask

    task automatic idle();
        dec_valid = 0; dec_branch = 0; dec_jump = 0;
        dec_pc_sel = 2'd1; dec_pc_we = 1; ex_br_taken = 0;
    endtask

    task automatic branch(input bit jmp);
        dec_valid = 1; dec_branch = !jmp; dec_jump = jmp;
        imem_ready = 1;
        step();
        chk("cf_we", a_we, 0);
        chk("cf_kill", a_kill, 1);
        idle();
    endtask

    initial begin
        // boot
        rst = 1; imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_sel", a_sel, 0);
            chk("rst_kill", a_kill, 1);
            chk("rst_busy", a_busy, 1);
        end
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("boot_we", a_we, 0);
            chk("boot_sel", a_sel, 0);
        end
        imem_ready = 1;
        step();
        chk("boot_go_we", a_we, 1);
        chk("boot_go_sel", a_sel, 0);
        // straight-line with imem toggling
        dec_valid = 1; dec_pc_sel = 2'd1; dec_pc_we = 1;
        for (int i = 0; i < 3; i++) begin
            imem_ready = (i != 1);
            step();
            chk("sl_busy", a_busy, 0);
            chk("sl_we", a_we, (i != 1) ? 1 : 0);
            chk("sl_kill", a_kill, (i == 1) ? 1 : 0);
        end
        // taken branch, LAT=2
        branch(0);
        step();
        chk("tb_wait_we", a_we, 0);
        chk("tb_wait_kill", a_kill, 1);
        ex_br_taken = 1;
        step();
        chk("tb_res_sel", a_sel, 2);
        chk("tb_res_we", a_we, 1);
        ex_br_taken = 0;
        step();
        chk("tb_run_busy", a_busy, 0);
        // not-taken branch, then JAL
        branch(0);
        step();
        step();
        chk("nt_sel", a_sel, 1);
        chk("nt_we", a_we, 1);
        branch(1);
        step();
        step();
        chk("jal_sel", a_sel, 2);
        chk("jal_we", a_we, 1);
        // redirect under back-pressure
        branch(0);
        step();
        ex_br_taken = 1; imem_ready = 0;
        step();
        chk("rd_res_we", a_we, 0);
        ex_br_taken = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rd_hold_sel", a_sel, 2);
            chk("rd_hold_we", a_we, 0);
        end
        imem_ready = 1;
        step();
        chk("rd_go_sel", a_sel, 2);
        chk("rd_go_we", a_we, 1);
        // backend stall mid-WAIT_BR delays resolution by 4
        branch(0);
        be_stall = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("st_we", a_we, 0);
            chk("st_kill", a_kill, 0);
            chk("st_busy", a_busy, 1);
        end
        be_stall = 0;
        step();
        chk("st_wait_we", a_we, 0);
        ex_br_taken = 1;
        step();
        chk("st_res_sel", a_sel, 2);
        chk("st_res_we", a_we, 1);
        idle();
        // reset while a redirect is pending
        branch(0);
        step();
        ex_br_taken = 1; imem_ready = 0;
        step();
        ex_br_taken = 0;
        step();
        rst = 1; imem_ready = 1;
        step();
        chk("rr_sel", a_sel, 0);
        chk("rr_we", a_we, 0);
        rst = 0;
        step();
        chk("rr_boot_sel", a_sel, 0);
        chk("rr_boot_we", a_we, 1);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            be_stall = ($urandom_range(0, 4) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            dec_valid = ($urandom_range(0, 3) != 0);
            dec_branch = ($urandom_range(0, 5) == 0);
            dec_jump = ($urandom_range(0, 9) == 0);
            dec_pc_sel = 2'($urandom_range(0, 2));
            dec_pc_we = 1'($urandom_range(0, 1));
            if (!be_stall) ex_br_taken = 1'($urandom_range(0, 1));
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
